mips_fetch: RTL
===============

Name: mips_fetch

Overview:
- Instruction-fetch stage of the single-issue MIPS pipeline. It sits directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM address. It captures the returned instruction word into the IF/ID pipeline register for the decode stage.
- Handles sequential fetch, branch/jump redirects from decode (architectural delay slot preserved), pipeline stalls, and a sticky fault/halt on illegal fetch addresses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ROM_BYTES, 32'h0000_00F0, size of the instruction ROM in bytes; a fetch at or above this address is illegal.
NOP_WORD, 32'h0000_0000, instruction word placed in IF/ID when it holds no valid instruction.
COUNT_W, 32, width of the retired-fetch counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
imem_addr  out  32  byte address to instruction ROM; combinationally equal to the PC register.
imem_data  in  32  instruction word from ROM; valid in the same cycle.
stall  in  1  hazard stall from decode/hazard unit; freezes PC and IF/ID.
redirect_valid  in  1  decode resolved a taken branch/jump this cycle.
redirect_target  in  32  byte address of the branch/jump target.
id_valid  out  1  IF/ID holds a real instruction.
id_instr  out  32  IF/ID instruction word.
id_pc  out  32  address of id_instr.
id_pc_plus4  out  32  id_pc + 4; used by decode for jal link and branch offsets.
fault  out  1  sticky illegal-fetch flag.
fetch_count  out  COUNT_W  number of instructions captured into IF/ID.

Behaviour:
- Reset, asynchronous and immediate (including mid-operation):
  - pc = RESET_PC, state = BOOT.
  - id_valid = 0, id_instr = NOP_WORD, id_pc = 0, id_pc_plus4 = 0.
  - fault = 0, fetch_count = 0.
- State machine: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle after reset deassertion. Nothing is captured and id_valid stays 0. Next state is RUN unconditionally; stall and redirect are ignored.
- RUN, stall = 0, pc legal (pc < ROM_BYTES and pc[1:0] == 0):
  - IF/ID: id_instr <= imem_data, id_pc <= pc, id_pc_plus4 <= pc + 4, id_valid <= 1.
  - fetch_count increments and saturates at all-ones.
  - Next PC: pc <= redirect_valid ? redirect_target : pc + 4 (32-bit modulo arithmetic).
- Fetch latency: the instruction at address A appears on id_instr one clock edge after pc == A.
- Delay slot: a redirect never squashes IF/ID. The word fetched in the redirect cycle (the slot after the branch) is captured normally. The target is fetched on the following cycle.
- RUN, stall = 1:
  - pc, all IF/ID outputs and fetch_count hold.
  - redirect_valid is ignored; decode re-asserts it once the stall clears, since the branch is held in ID.
  - A stall with an illegal pc holds; it does not fault until the fetch is actually attempted.
- RUN, stall = 0, pc illegal:
  - state <= HALT, fault <= 1, id_valid <= 0, id_instr <= NOP_WORD. pc holds.
  - Any simultaneous redirect is ignored.
- HALT: all registers hold, fault = 1, id_valid = 0, and stall/redirect are ignored. Only rst exits.
- A misaligned or out-of-range redirect_target is accepted into pc. The fault is raised on the next unstalled fetch cycle.
- imem_addr always equals pc, in every state.

Test Plan:
- Reset release with the fib program image in ROM: cycle 1 id_valid = 0. After the 2nd edge, id_valid = 1, id_instr = 32'h27BDFFE0, id_pc = 0, id_pc_plus4 = 4. After the 3rd edge, id_instr = 32'hAFBF001C.
- Jal with delay slot: pulse redirect_valid = 1 with target 32'h44 in the cycle where id_pc = 32'h14. The next capture is id_pc = 32'h18 with 32'h00200825, followed by id_pc = 32'h44 with 32'h27BDFFD8.
- Stall: hold stall = 1 for 3 cycles at id_pc = 32'h0C, with redirect_valid = 1 during the stall. id_instr stays 32'h03A0F021 and fetch_count is unchanged. After release, id_pc = 32'h10 and the redirect has no effect.
- Out-of-range fetch: redirect to 32'hF0. One cycle later, fault = 1 and id_valid = 0. fault stays 1 across 10 further cycles with pulsed redirect/stall. imem_addr stays 32'hF0.
- Misaligned target: redirect to 32'h46. The pc = 32'h46 cycle produces fault = 1 and id_instr = NOP_WORD.
- Async reset mid-run: assert rst between clock edges at pc = 32'h80. All outputs reach their reset values before the next edge. The fetch sequence restarts with BOOT and then address 0.

Source files
------------

// File: rtl/mips_fetch.sv
// ============================================================================
//  Module   : mips_fetch
//  Purpose  : Instruction-fetch stage of the single-issue MIPS pipeline.
//             It owns the program counter, addresses the combinational
//             instruction ROM and registers the returned word into the
//             IF/ID pipeline register. It handles sequential fetch,
//             delayed-branch redirects, hazard stalls and a sticky
//             halt on illegal fetch addresses.
//
//  Ports    : clk, rst          - rising-edge clock, async active-high reset
//             imem_addr         - ROM byte address (always equal to the PC)
//             imem_data         - ROM instruction word (same-cycle)
//             stall             - freeze PC, IF/ID and the fetch counter
//             redirect_valid    - taken branch/jump resolved in decode
//             redirect_target   - byte address of the branch/jump target
//             id_valid, id_instr, id_pc, id_pc_plus4 - IF/ID register
//             fault             - sticky illegal-fetch flag
//             fetch_count       - saturating count of captured instructions
//
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ROM_BYTES = 32'h0000_00F0,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter int          COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic               id_valid,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc_plus4,
    output logic               fault,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        pc_legal;
    logic [31:0] pc_plus4;

    // A fetch is legal only for a word-aligned address inside the ROM.
    assign pc_legal  = (pc < ROM_BYTES) && (pc[1:0] == 2'b00);
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= NOP_WORD;
            id_pc       <= 32'd0;
            id_pc_plus4 <= 32'd0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                // One idle cycle after reset release; inputs are ignored.
                ST_BOOT: begin
                    state <= ST_RUN;
                end

                ST_RUN: begin
                    // A stall freezes everything, including a pending
                    // redirect: decode holds the branch and re-asserts it.
                    if (!stall) begin
                        if (pc_legal) begin
                            // The word fetched alongside a redirect is the
                            // delay slot, so it is captured, never squashed.
                            id_instr    <= imem_data;
                            id_pc       <= pc;
                            id_pc_plus4 <= pc_plus4;
                            id_valid    <= 1'b1;
                            if (fetch_count != '1) begin
                                fetch_count <= fetch_count + COUNT_W'(1);
                            end
                            pc <= redirect_valid ? redirect_target : pc_plus4;
                        end else begin
                            // Illegal address only faults when the fetch is
                            // actually attempted; pc is left pointing at it.
                            state    <= ST_HALT;
                            fault    <= 1'b1;
                            id_valid <= 1'b0;
                            id_instr <= NOP_WORD;
                        end
                    end
                end

                // HALT (and the unused encoding) hold every register.
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
